rat_int_ctrl: RTL and testbench

- Prioritised, maskable interrupt controller that sits in front of the RAT control unit's single INTV input.
- Collects up to 8 edge-triggered sources and latches them as pending.
- Arbitrates lowest-index-first, holds INTV until the control unit acknowledges, then blocks further requests until software writes end-of-interrupt (EOI).
- Mask, pending, active-ID and EOI are reached through the existing IN/OUT port bus (PORT_ID, IO_STRB).

---
 rtl/rat_int_pkg.sv | 28 ++
 rtl/rat_int_edge_latch.sv | 36 +++
 rtl/rat_int_ctrl.sv | 129 ++++++++++++
 tb/tb_rat_int_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rat_int_pkg.sv
// Shared types, default port addresses and the priority helper for the
// RAT interrupt controller.
package rat_int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } int_state_t;

    localparam int          MAX_SRC       = 8;
    localparam logic [7:0]  MASK_PORT_DEF = 8'h30;
    localparam logic [7:0]  EOI_PORT_DEF  = 8'h31;
    localparam logic [7:0]  ID_PORT_DEF   = 8'h32;
    localparam logic [7:0]  PEND_PORT_DEF = 8'h33;

    // Index of the lowest set bit; 0 when the vector is empty (callers
    // only use the result when at least one bit is set).
    function automatic logic [2:0] prio_lowest(input logic [7:0] vec);
        logic [2:0] idx;
        idx = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) idx = i[2:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/rat_int_edge_latch.sv
// Rising-edge detector and pending latch for NUM_SRC interrupt sources.
// A new edge always wins over a same-cycle clear so no event is lost.
module rat_int_edge_latch #(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic [NUM_SRC-1:0] clr_i,
    output logic [NUM_SRC-1:0] pending_o
);

    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] edge_w;

    assign edge_w    = irq_i & ~irq_q;
    assign pending_o = pend_q;

    // Next pending: clear the acknowledged bit, then OR in fresh edges.
    always_comb begin
        pend_d = (pend_q & ~clr_i) | edge_w;
    end

    // Source history and pending registers.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            irq_q  <= '0;
            pend_q <= '0;
        end else begin
            irq_q  <= irq_i;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/rat_int_ctrl.sv
// Prioritised, maskable interrupt controller in front of the RAT INTV
// input. Lowest index wins; one request is in flight until software EOI.
module rat_int_ctrl
    import rat_int_pkg::*;
#(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] MASK_PORT = MASK_PORT_DEF,
    parameter logic [7:0] EOI_PORT  = EOI_PORT_DEF,
    parameter logic [7:0] ID_PORT   = ID_PORT_DEF,
    parameter logic [7:0] PEND_PORT = PEND_PORT_DEF
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic [NUM_SRC-1:0] IRQ,
    input  logic               INT_EN,
    input  logic               INT_ACK,
    input  logic [7:0]         PORT_ID,
    input  logic [7:0]         OUT_PORT,
    input  logic               IO_STRB,
    output logic               INTV,
    output logic [7:0]         IN_DATA,
    output logic               IN_HIT,
    output logic [2:0]         ACTIVE_ID
);

    int_state_t         state_q, state_d;
    logic [2:0]         active_q, active_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] clr;
    logic [7:0]         req8, mask8, pend8;
    logic               ack_take;
    logic               eoi;
    logic               mask_wr;

    // Upper data bits beyond NUM_SRC are deliberately ignored on mask writes.
    wire unused_out = &{1'b0, OUT_PORT};

    assign eoi       = IO_STRB && (PORT_ID == EOI_PORT);
    assign mask_wr   = IO_STRB && (PORT_ID == MASK_PORT);
    assign INTV      = (state_q == ASSERT);
    assign ACTIVE_ID = active_q;

    rat_int_edge_latch #(.NUM_SRC(NUM_SRC)) u_latch (
        .clk       (clk),
        .rst_i     (RESET),
        .irq_i     (IRQ),
        .clr_i     (clr),
        .pending_o (pending)
    );

    // Zero-extend mask, pending and request vectors to the 8-bit bus width.
    always_comb begin
        mask8 = '0;
        pend8 = '0;
        req8  = '0;
        mask8[NUM_SRC-1:0] = mask_q;
        pend8[NUM_SRC-1:0] = pending;
        req8[NUM_SRC-1:0]  = pending & mask_q;
    end

    // One-hot clear of the granted source on an accepted acknowledge.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr[i] = ack_take && (active_q == 3'(i));
        end
    end

    // Arbitration FSM: grant, hold INTV until ACK, then wait for EOI.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        ack_take = 1'b0;
        mask_d   = mask_wr ? OUT_PORT[NUM_SRC-1:0] : mask_q;
        case (state_q)
            IDLE: begin
                if (INT_EN && (req8 != 8'h00)) begin
                    active_d = prio_lowest(req8);
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                if (INT_ACK) begin
                    ack_take = 1'b1;
                    state_d  = SERVICE;
                end else if (!INT_EN || !req8[active_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, granted ID and mask registers.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q  <= IDLE;
            active_q <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            mask_q   <= mask_d;
        end
    end

    // Combinational IN-port read mux.
    always_comb begin
        IN_DATA = 8'h00;
        IN_HIT  = 1'b0;
        if (PORT_ID == MASK_PORT) begin
            IN_HIT  = 1'b1;
            IN_DATA = mask8;
        end else if (PORT_ID == ID_PORT) begin
            IN_HIT  = 1'b1;
            IN_DATA = {state_q == SERVICE, state_q == ASSERT, 3'b000, active_q};
        end else if (PORT_ID == PEND_PORT) begin
            IN_HIT  = 1'b1;
            IN_DATA = pend8;
        end else if (PORT_ID == EOI_PORT) begin
            IN_HIT  = 1'b1;
        end
    end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Self-checking bench for rat_int_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_rat_int_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         RESET, INT_EN, INT_ACK, IO_STRB;
    logic [N-1:0] IRQ;
    logic [7:0]   PORT_ID, OUT_PORT, IN_DATA;
    logic         INTV, IN_HIT;
    logic [2:0]   ACTIVE_ID;

    int total = 0;
    int bad   = 0;

    rat_int_ctrl #(.NUM_SRC(N)) dut (
        .clk(clk), .RESET(RESET), .IRQ(IRQ), .INT_EN(INT_EN), .INT_ACK(INT_ACK),
        .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB),
        .INTV(INTV), .IN_DATA(IN_DATA), .IN_HIT(IN_HIT), .ACTIVE_ID(ACTIVE_ID)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] port, input logic [7:0] exp, input string nm);
        PORT_ID = port;
        #1;
        chk(nm, IN_DATA, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] irq;
        logic         en, ack, strb;
        logic [7:0]   port, data;
        logic         exp_intv;
        logic [2:0]   exp_id;
        logic [7:0]   exp_rd;
    } vec_t;

    vec_t tbl[24];

    // ---------------- behavioural model ----------------
    // mode: 0 = nothing outstanding, 1 = requesting CPU, 2 = CPU servicing
    logic [N-1:0] m_pend, m_mask, m_prev;
    int           m_mode;
    int           m_id;

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0; m_mode = 0; m_id = 0;
    endtask

    task automatic model_step(input logic [N-1:0] irq, input logic en, input logic ack,
                              input logic strb, input logic [7:0] port, input logic [7:0] data);
        logic [N-1:0] req, nxt;
        req = m_pend & m_mask;
        nxt = m_pend;
        if (m_mode == 0) begin
            if (en && req != 0) begin
                for (int i = N - 1; i >= 0; i--) if (req[i]) m_id = i;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (ack) begin
                nxt[m_id] = 1'b0;
                m_mode = 2;
            end else if (!en || !req[m_id]) begin
                m_mode = 0;
            end
        end else begin
            if (strb && port == 8'h31) m_mode = 0;
        end
        m_pend = nxt | (irq & ~m_prev);
        m_prev = irq;
        if (strb && port == 8'h30) m_mask = data[N-1:0];
    endtask

    function automatic logic [8:0] model_read(input logic [7:0] port);
        case (port)
            8'h30: return {1'b1, 8'(m_mask)};
            8'h31: return {1'b1, 8'h00};
            8'h32: return {1'b1, m_mode == 2, m_mode == 1, 3'b000, 3'(m_id)};
            8'h33: return {1'b1, 8'(m_pend)};
            default: return 9'h000;
        endcase
    endfunction

    initial begin
        logic [8:0] mr;
        RESET = 1'b1; IRQ = '0; INT_EN = 1'b1; INT_ACK = 1'b0;
        IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;

        //        irq   en ack strb port   data   intv id  rd
        tbl[0]  = '{4'h0, 1, 0, 1, 8'h30, 8'h0F, 0, 3'd0, 8'h0F};
        tbl[1]  = '{4'h4, 1, 0, 0, 8'h33, 8'h00, 0, 3'd0, 8'h04};
        tbl[2]  = '{4'h4, 1, 0, 0, 8'h32, 8'h00, 1, 3'd2, 8'h42};
        tbl[3]  = '{4'h0, 1, 1, 0, 8'h33, 8'h00, 0, 3'd2, 8'h00};
        tbl[4]  = '{4'h0, 1, 0, 1, 8'h31, 8'h00, 0, 3'd2, 8'h00};
        tbl[5]  = '{4'hA, 1, 0, 0, 8'h33, 8'h00, 0, 3'd2, 8'h0A};
        tbl[6]  = '{4'hA, 1, 0, 0, 8'h32, 8'h00, 1, 3'd1, 8'h41};
        tbl[7]  = '{4'h0, 1, 1, 0, 8'h33, 8'h00, 0, 3'd1, 8'h08};
        tbl[8]  = '{4'h0, 1, 0, 1, 8'h31, 8'h00, 0, 3'd1, 8'h00};
        tbl[9]  = '{4'h0, 1, 0, 0, 8'h32, 8'h00, 1, 3'd3, 8'h43};
        tbl[10] = '{4'h0, 1, 1, 0, 8'h33, 8'h00, 0, 3'd3, 8'h00};
        tbl[11] = '{4'h0, 1, 0, 1, 8'h31, 8'h00, 0, 3'd3, 8'h00};
        tbl[12] = '{4'h2, 1, 0, 0, 8'h33, 8'h00, 0, 3'd3, 8'h02};
        tbl[13] = '{4'h2, 1, 0, 0, 8'h32, 8'h00, 1, 3'd1, 8'h41};
        tbl[14] = '{4'h0, 0, 0, 0, 8'h33, 8'h00, 0, 3'd1, 8'h02};
        tbl[15] = '{4'h0, 0, 0, 0, 8'h33, 8'h00, 0, 3'd1, 8'h02};
        tbl[16] = '{4'h0, 1, 0, 0, 8'h32, 8'h00, 1, 3'd1, 8'h41};
        tbl[17] = '{4'h0, 1, 1, 0, 8'h32, 8'h00, 0, 3'd1, 8'h81};
        tbl[18] = '{4'h1, 1, 0, 0, 8'h33, 8'h00, 0, 3'd1, 8'h01};
        tbl[19] = '{4'h1, 1, 0, 0, 8'h32, 8'h00, 0, 3'd1, 8'h81};
        tbl[20] = '{4'h0, 1, 0, 1, 8'h31, 8'h00, 0, 3'd1, 8'h00};
        tbl[21] = '{4'h0, 1, 0, 0, 8'h32, 8'h00, 1, 3'd0, 8'h40};
        tbl[22] = '{4'h0, 1, 1, 0, 8'h33, 8'h00, 0, 3'd0, 8'h00};
        tbl[23] = '{4'h0, 1, 0, 1, 8'h31, 8'h00, 0, 3'd0, 8'h00};

        // Reset state
        cyc(); cyc();
        RESET = 1'b0;
        chk("rst_intv", 8'(INTV), 8'h00);
        chk("rst_id", 8'(ACTIVE_ID), 8'h00);
        rd(8'h30, 8'h00, "rst_mask");
        rd(8'h32, 8'h00, "rst_idport");
        rd(8'h33, 8'h00, "rst_pend");
        PORT_ID = 8'h55; #1; chk("hit_other", 8'(IN_HIT), 8'h00);
        chk("data_other", IN_DATA, 8'h00);
        PORT_ID = 8'h31; #1; chk("hit_eoi", 8'(IN_HIT), 8'h01);

        // Directed table
        foreach (tbl[k]) begin
            IRQ = tbl[k].irq; INT_EN = tbl[k].en; INT_ACK = tbl[k].ack;
            IO_STRB = tbl[k].strb; PORT_ID = tbl[k].port; OUT_PORT = tbl[k].data;
            cyc();
            chk($sformatf("v%0d_intv", k), 8'(INTV), 8'(tbl[k].exp_intv));
            chk($sformatf("v%0d_id", k), 8'(ACTIVE_ID), 8'(tbl[k].exp_id));
            chk($sformatf("v%0d_rd", k), IN_DATA, tbl[k].exp_rd);
        end
        IRQ = '0; INT_EN = 1'b1; INT_ACK = 1'b0; IO_STRB = 1'b0;

        // Held level on IRQ[0] yields a single pending event
        IRQ = 4'h1; cyc(); cyc();
        chk("hold_intv", 8'(INTV), 8'h01);
        INT_ACK = 1'b1; cyc(); INT_ACK = 1'b0;
        PORT_ID = 8'h31; IO_STRB = 1'b1; cyc(); IO_STRB = 1'b0;
        for (int c = 0; c < 16; c++) cyc();
        chk("hold_intv_after", 8'(INTV), 8'h00);
        rd(8'h33, 8'h00, "hold_pend");
        IRQ = 4'h0; cyc();

        // ACK coincident with a fresh IRQ[0] edge keeps the new event
        IRQ = 4'h1; cyc();
        IRQ = 4'h0; cyc();
        chk("coin_intv", 8'(INTV), 8'h01);
        IRQ = 4'h1; INT_ACK = 1'b1; cyc();
        IRQ = 4'h0; INT_ACK = 1'b0;
        rd(8'h33, 8'h01, "coin_pend");
        rd(8'h32, 8'h80, "coin_idport");
        PORT_ID = 8'h31; IO_STRB = 1'b1; cyc(); IO_STRB = 1'b0;
        cyc();
        chk("coin_reassert", 8'(INTV), 8'h01);
        chk("coin_id", 8'(ACTIVE_ID), 8'h00);

        // Reset while asserting
        RESET = 1'b1; cyc(); RESET = 1'b0;
        chk("rstA_intv", 8'(INTV), 8'h00);
        rd(8'h30, 8'h00, "rstA_mask");
        rd(8'h33, 8'h00, "rstA_pend");
        rd(8'h32, 8'h00, "rstA_idport");

        // Randomized run against the model
        model_reset();
        for (int c = 0; c < 600; c++) begin
            int r;
            IRQ     = N'($urandom);
            INT_EN  = ($urandom % 8) != 0;
            INT_ACK = (m_mode == 1) ? (($urandom % 3) == 0)
                    : (m_mode == 2) ? (($urandom % 8) == 0) : 1'b0;
            r = $urandom % 6;
            PORT_ID = (r == 0) ? 8'h30 : (r == 1) ? 8'h31 : (r == 2) ? 8'h32 :
                      (r == 3) ? 8'h33 : 8'(8'h40 + $urandom % 64);
            IO_STRB  = ($urandom % 3) == 0;
            OUT_PORT = 8'($urandom);
            model_step(IRQ, INT_EN, INT_ACK, IO_STRB, PORT_ID, OUT_PORT);
            cyc();
            mr = model_read(PORT_ID);
            chk("rnd_intv", 8'(INTV), 8'(m_mode == 1));
            chk("rnd_id", 8'(ACTIVE_ID), 8'(m_id));
            chk("rnd_data", IN_DATA, mr[7:0]);
            chk("rnd_hit", 8'(IN_HIT), 8'(mr[8]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
